// File: rtl/wb_sram_resp.sv
// Arbitrates a read-only instruction Wishbone port and a read/write data Wishbone port
// onto one single-port SRAM macro. Each access takes a grant cycle and then an ack cycle.
module wb_sram_resp #(
   parameter int AW = 9
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wb_imem_stb_i,
   input  logic          wb_imem_cyc_i,
   input  logic [31:0]   wb_imem_adr_i,
   output logic [31:0]   wb_imem_dat_o,
   output logic          wb_imem_ack_o,
   input  logic          wb_dmem_stb_i,
   input  logic          wb_dmem_cyc_i,
   input  logic          wb_dmem_we_i,
   input  logic [3:0]    wb_dmem_be_i,
   input  logic [31:0]   wb_dmem_adr_i,
   input  logic [31:0]   wb_dmem_dat_i,
   output logic [31:0]   wb_dmem_dat_o,
   output logic          wb_dmem_ack_o,
   output logic          sram_ce_o,
   output logic          sram_we_o,
   output logic [3:0]    sram_be_o,
   output logic [AW-1:0] sram_adr_o,
   output logic [31:0]   sram_dat_o,
   input  logic [31:0]   sram_dat_i,
   output logic [1:0]    dbg_state
);

   // Handshake: a port requests while stb&cyc=1; ack is a single-cycle pulse in the
   // cycle after the grant, given only if the request is still held in that cycle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK_I = 2'd1,
      ACK_D = 2'd2
   } state_t;

   state_t state;
   logic   last_d;
   logic   d_wr;
   logic   imem_pend;
   logic   dmem_pend;
   logic   grant_i;
   logic   grant_d;

   assign imem_pend = wb_imem_stb_i & wb_imem_cyc_i;
   assign dmem_pend = wb_dmem_stb_i & wb_dmem_cyc_i;
   assign dbg_state = state;

   // On a tie, the port that did not win last time gets the SRAM.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!rst_i && state == IDLE) begin
         grant_i = imem_pend & (~dmem_pend | last_d);
         grant_d = dmem_pend & ~grant_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         last_d <= 1'b1;
         d_wr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state  <= ACK_I;
                  last_d <= 1'b0;
               end else if (grant_d) begin
                  state  <= ACK_D;
                  last_d <= 1'b1;
                  d_wr   <= wb_dmem_we_i;
               end
            end
            ACK_I:   state <= IDLE;
            ACK_D:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      sram_ce_o     = grant_i | grant_d;
      sram_we_o     = 1'b0;
      sram_be_o     = 4'b0000;
      sram_adr_o    = '0;
      sram_dat_o    = 32'h0;
      if (grant_i) begin
         sram_adr_o = wb_imem_adr_i[AW+1:2];
      end else if (grant_d) begin
         sram_adr_o = wb_dmem_adr_i[AW+1:2];
         sram_we_o  = wb_dmem_we_i;
         sram_be_o  = wb_dmem_we_i ? wb_dmem_be_i : 4'b0000;
         sram_dat_o = wb_dmem_dat_i;
      end
   end

   // Acks are masked during reset so an interrupted access is never acknowledged.
   always_comb begin
      wb_imem_ack_o = !rst_i && state == ACK_I && imem_pend;
      wb_dmem_ack_o = !rst_i && state == ACK_D && dmem_pend;
      wb_imem_dat_o = wb_imem_ack_o ? sram_dat_i : 32'h0;
      wb_dmem_dat_o = (wb_dmem_ack_o && !d_wr) ? sram_dat_i : 32'h0;
   end

endmodule

// File: tb/tb_wb_sram_resp.sv
// Directed and randomised bench for wb_sram_resp with a behavioural SRAM, a reference
// memory and per-port expected-data queues checked on every ack.
module tb_wb_sram_resp;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_stb = 1'b0, i_cyc = 1'b0;
   logic [31:0]   i_adr = 32'h0;
   logic [31:0]   i_dat;
   logic          i_ack;
   logic          d_stb = 1'b0, d_cyc = 1'b0, d_we = 1'b0;
   logic [3:0]    d_be = 4'h0;
   logic [31:0]   d_adr = 32'h0, d_wdat = 32'h0;
   logic [31:0]   d_dat;
   logic          d_ack;
   logic          sram_ce, sram_we;
   logic [3:0]    sram_be;
   logic [AW-1:0] sram_adr;
   logic [31:0]   sram_wdat;
   logic [31:0]   sram_rdat;
   logic [1:0]    dbg_state;

   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_adr = '0;
   logic [31:0]   pre_dat = 32'h0;
   logic [31:0]   mem [1<<AW];
   logic [31:0]   ref_mem [1<<AW];
   logic [31:0]   imem_q[$];
   logic [31:0]   dmem_q[$];
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   wb_sram_resp #(.AW(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_imem_stb_i(i_stb), .wb_imem_cyc_i(i_cyc), .wb_imem_adr_i(i_adr),
      .wb_imem_dat_o(i_dat), .wb_imem_ack_o(i_ack),
      .wb_dmem_stb_i(d_stb), .wb_dmem_cyc_i(d_cyc), .wb_dmem_we_i(d_we),
      .wb_dmem_be_i(d_be), .wb_dmem_adr_i(d_adr), .wb_dmem_dat_i(d_wdat),
      .wb_dmem_dat_o(d_dat), .wb_dmem_ack_o(d_ack),
      .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_be_o(sram_be),
      .sram_adr_o(sram_adr), .sram_dat_o(sram_wdat), .sram_dat_i(sram_rdat),
      .dbg_state(dbg_state)
   );

   // Behavioural SRAM: read data appears the cycle after the access.
   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_adr] <= pre_dat;
      end else if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_adr][8*b +: 8] <= sram_wdat[8*b +: 8];
         end else begin
            sram_rdat <= mem[sram_adr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (i_ack) begin
         chk("imem_ack_expected", 32'(imem_q.size() > 0), 32'd1);
         if (imem_q.size() > 0) chk("imem_dat", i_dat, imem_q.pop_front());
      end else begin
         chk("imem_dat_idle", i_dat, 32'h0);
      end
      if (d_ack) begin
         chk("dmem_ack_expected", 32'(dmem_q.size() > 0), 32'd1);
         if (dmem_q.size() > 0) chk("dmem_dat", d_dat, dmem_q.pop_front());
      end else begin
         chk("dmem_dat_idle", d_dat, 32'h0);
      end
      if (i_ack || d_ack) chk("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] idx, input logic [31:0] dat);
      pre_en = 1'b1; pre_adr = idx; pre_dat = dat;
      ref_mem[idx] = dat;
      step();
      pre_en = 1'b0;
   endtask

   task automatic imem_read(input logic [31:0] adr);
      i_stb = 1'b1; i_cyc = 1'b1; i_adr = adr;
      imem_q.push_back(ref_mem[adr[AW+1:2]]);
      @(negedge clk);
      chk("i_grant_ce", 32'(sram_ce), 32'd1);
      chk("i_grant_we", 32'(sram_we), 32'd0);
      chk("i_grant_adr", 32'(sram_adr), 32'(adr[AW+1:2]));
      step();
      @(negedge clk);
      chk("i_ack", 32'(i_ack), 32'd1);
      step();
      i_stb = 1'b0; i_cyc = 1'b0;
   endtask

   task automatic dmem_xfer(input logic we, input logic [3:0] be, input logic [31:0] adr,
                            input logic [31:0] dat);
      logic [AW-1:0] idx;
      idx = adr[AW+1:2];
      d_stb = 1'b1; d_cyc = 1'b1; d_we = we; d_be = be; d_adr = adr; d_wdat = dat;
      dmem_q.push_back(we ? 32'h0 : ref_mem[idx]);
      if (we)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      @(negedge clk);
      chk("d_grant_ce", 32'(sram_ce), 32'd1);
      chk("d_grant_we", 32'(sram_we), 32'(we));
      chk("d_grant_be", 32'(sram_be), we ? 32'(be) : 32'd0);
      chk("d_grant_adr", 32'(sram_adr), 32'(idx));
      chk("d_grant_wdat", sram_wdat, dat);
      step();
      @(negedge clk);
      chk("d_ack", 32'(d_ack), 32'd1);
      chk("d_ack_ce", 32'(sram_ce), 32'd0);
      step();
      d_stb = 1'b0; d_cyc = 1'b0; d_we = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ridx [6];
      // Reset: all outputs quiet.
      repeat (3) step();
      @(negedge clk);
      chk("rst_ce", 32'(sram_ce), 32'd0);
      chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_state", 32'(dbg_state), 32'd0);
      chk("post_rst_sram", {sram_we, sram_be, 27'(sram_adr)}, 32'h0);
      chk("post_rst_wdat", sram_wdat, 32'h0);
      step();

      preload(9'h1C, 32'h0000_0013);
      preload(9'h41, 32'h1122_3344);
      preload(9'h30, 32'hCAFE_F00D);

      imem_read(32'h0000_0070);
      dmem_xfer(1'b1, 4'b0010, 32'h0000_0104, 32'hAABB_CCDD);
      chk("byte_merge_model", ref_mem[9'h41], 32'h1122_CC44);
      dmem_xfer(1'b0, 4'b0000, 32'h0000_0104, 32'h0);
      dmem_xfer(1'b1, 4'b1111, 32'h0000_0800, 32'hDEAD_BEEF);
      imem_read(32'h0000_0000);
      dmem_xfer(1'b1, 4'b0000, 32'h0000_0070, 32'hFFFF_FFFF);
      imem_read(32'hFFFF_F871);

      // Contention from reset: grants alternate I, D, I, D.
      rst = 1'b1;
      i_stb = 1'b1; i_cyc = 1'b1; i_adr = 32'h0000_0070;
      d_stb = 1'b1; d_cyc = 1'b1; d_we = 1'b0; d_be = 4'hF; d_adr = 32'h0000_00C0;
      @(negedge clk);
      chk("rst_ce_with_req", 32'(sram_ce), 32'd0);
      step();
      rst = 1'b0;
      repeat (2) imem_q.push_back(ref_mem[9'h1C]);
      repeat (2) dmem_q.push_back(ref_mem[9'h30]);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("cont_ce", 32'(sram_ce), 32'(c % 2 == 0));
         chk("cont_i_ack", 32'(i_ack), 32'(c % 4 == 1));
         chk("cont_d_ack", 32'(d_ack), 32'(c % 4 == 3));
         if (c % 2 == 0) chk("cont_adr", 32'(sram_adr), (c % 4 == 0) ? 32'h1C : 32'h30);
         step();
      end
      i_stb = 1'b0; i_cyc = 1'b0; d_stb = 1'b0; d_cyc = 1'b0;
      step();

      // Reset during ACK_D of a read: ack suppressed, then re-served.
      d_stb = 1'b1; d_cyc = 1'b1; d_we = 1'b0; d_adr = 32'h0000_0104;
      @(negedge clk);
      chk("rd_rst_grant", 32'(sram_ce), 32'd1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rd_rst_no_ack", 32'(d_ack), 32'd0);
      step();
      rst = 1'b0;
      dmem_q.push_back(32'h1122_CC44);
      @(negedge clk);
      chk("rd_rst_reissue_ce", 32'(sram_ce), 32'd1);
      chk("rd_rst_reissue_adr", 32'(sram_adr), 32'h41);
      step();
      @(negedge clk);
      chk("rd_rst_ack", 32'(d_ack), 32'd1);
      step();
      d_stb = 1'b0; d_cyc = 1'b0;
      step();

      // Abandoned imem cycle.
      i_stb = 1'b1; i_cyc = 1'b1; i_adr = 32'h0000_0070;
      step();
      i_stb = 1'b0; i_cyc = 1'b0;
      @(negedge clk);
      chk("abandon_state", 32'(dbg_state), 32'd1);
      chk("abandon_no_ack", 32'(i_ack), 32'd0);
      step();
      @(negedge clk);
      chk("abandon_idle", 32'(dbg_state), 32'd0);
      chk("abandon_ce", 32'(sram_ce), 32'd0);
      step();

      // Random writes, read back through alternating ports.
      for (int k = 0; k < 6; k++) begin
         ridx[k] = AW'($urandom_range(64 + 16 * k, 64 + 16 * k + 15));
         dmem_xfer(1'b1, 4'hF, {21'($urandom_range(0, 7)), ridx[k], 2'b00}, $urandom);
      end
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) imem_read({21'h0, ridx[k], 2'b00});
         else dmem_xfer(1'b0, 4'h0, {21'h0, ridx[k], 2'b00}, 32'h0);
      end

      repeat (2) step();
      chk("imem_q_drained", 32'(imem_q.size()), 32'd0);
      chk("dmem_q_drained", 32'(dmem_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_sram_resp.md
WB_SRAM_RESP -- requirements
Module: wb_sram_resp

Interface
REQ-001 The block SHALL have parameter AW, default 9, giving the SRAM word-address width (512 words, 2 KiB).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 wb_imem_stb_i / wb_imem_cyc_i  in  1 each  instruction-port Wishbone classic request (read-only).
REQ-005 wb_imem_adr_i  in  32  instruction byte address; bits [AW+1:2] used.
REQ-006 wb_imem_dat_o  out  32  instruction read data; wb_imem_ack_o  out  1  instruction acknowledge.
REQ-007 wb_dmem_stb_i / wb_dmem_cyc_i / wb_dmem_we_i  in  1 each  data-port request and write enable.
REQ-008 wb_dmem_be_i  in  4  byte enables; wb_dmem_adr_i  in  32  byte address; wb_dmem_dat_i  in  32  write data.
REQ-009 wb_dmem_dat_o  out  32  data read data; wb_dmem_ack_o  out  1  data acknowledge.
REQ-010 sram_ce_o / sram_we_o  out  1 each  single-port SRAM macro chip enable and write enable.
REQ-011 sram_be_o  out  4  SRAM byte write mask; sram_adr_o  out  AW  word address; sram_dat_o  out  32  write data.
REQ-012 sram_dat_i  in  32  SRAM read data, valid exactly one cycle after a read access with sram_ce_o=1.

Function
REQ-013 A port SHALL be pending when its stb and cyc are both 1.
REQ-014 The FSM SHALL have exactly three states: IDLE, ACK_I, ACK_D.
REQ-015 In IDLE with a pending port, the block SHALL grant one port and, in that same cycle, drive sram_ce_o=1, sram_adr_o=adr[AW+1:2] of the granted port.
REQ-016 Imem grant: sram_we_o=0, sram_be_o=0; next state ACK_I.
REQ-017 Dmem grant: sram_we_o=wb_dmem_we_i, sram_be_o=wb_dmem_be_i when writing else 0, sram_dat_o=wb_dmem_dat_i; next state ACK_D.
REQ-018 With both ports pending in IDLE, the block SHALL grant the port not granted most recently (round-robin); a single pending port SHALL always be granted.
REQ-019 A one-bit last-grant register SHALL update on every grant.
REQ-020 In ACK_I/ACK_D, the corresponding ack SHALL be 1 for exactly that one cycle if the port is still pending, else 0 (abandoned cycle: the write is already performed, no ack).
REQ-021 ACK_I and ACK_D SHALL always return to IDLE the next cycle: latency stb->ack = 1 cycle; maximum throughput one access per 2 cycles.
REQ-022 The block SHALL drive sram_ce_o=0 in ACK_I and ACK_D; at most one SRAM access per 2 cycles.
REQ-023 wb_imem_dat_o SHALL equal sram_dat_i while wb_imem_ack_o=1, else 0.
REQ-024 wb_dmem_dat_o SHALL equal sram_dat_i on an acked dmem read, else 0 (including dmem write acks).
REQ-025 A dmem write with be=4'b0000 SHALL issue a no-op SRAM write and still ack.
REQ-026 Address bits [1:0] and [31:AW+2] SHALL be ignored; out-of-range addresses alias modulo 2^(AW+2) bytes.
REQ-027 The two acks SHALL never be 1 in the same cycle.
REQ-028 Outside a grant cycle, sram_adr_o, sram_dat_o, sram_we_o and sram_be_o SHALL be 0.

Reset
REQ-029 On rst_i=1 at a clock edge, the block SHALL enter IDLE with last-grant=dmem (imem wins the first tie).
REQ-030 All outputs SHALL be 0 during and after reset until the first grant.
REQ-031 Reset asserted in ACK_I/ACK_D SHALL suppress that ack; a pending master SHALL be re-served after reset as a new request.
REQ-032 While rst_i=1, sram_ce_o SHALL be 0 regardless of requests.

Verification
REQ-033 Imem read: preload word 0x1C=0x00000013; imem stb at adr 0x70 -> sram_ce_o=1, adr=0x1C in cycle 0; ack=1, dat_o=0x00000013 in cycle 1.
REQ-034 Byte write: dmem write adr 0x104, be=4'b0010, dat=0xAABBCCDD over word 0x11223344 -> SRAM mask 0010; readback 0x1122CC44; write ack with dat_o=0.
REQ-035 Contention: both ports pending continuously from reset -> grants alternate I,D,I,D; acks every other cycle, never simultaneous.
REQ-036 Aliasing: dmem write 0xDEADBEEF at 0x0000_0800 with AW=9 -> imem read at 0x0000_0000 returns 0xDEADBEEF.
REQ-037 Reset in ACK_D of a read -> no wb_dmem_ack_o; with stb still high, next access issued the first IDLE cycle after reset and acked.
REQ-038 Abandon: imem stb dropped in ACK_I cycle -> wb_imem_ack_o stays 0; FSM back in IDLE.
